// File: rtl/anubis_p_nibble_serializer.sv
// Nibble-serial Anubis P mini-box substitution: accepts a word, substitutes
// NPC nibbles per clock LSB-first in place, then holds the result for the consumer.
module anubis_p_nibble_serializer #(
  parameter int DATA_W = 128,
  parameter int NPC    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int GW = 4 * NPC;
  localparam int G  = DATA_W / GW;
  localparam int CW = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  generate
    if ((DATA_W % GW) != 0 || DATA_W < GW) begin : g_param_check
      $error("anubis_p_nibble_serializer: DATA_W must be a positive multiple of 4*NPC");
    end
  endgenerate

  // Anubis P mini-box; it is an involution, so applying it twice is identity.
  function automatic logic [3:0] p_box(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'h3;
      4'h1:    y = 4'hF;
      4'h2:    y = 4'hE;
      4'h3:    y = 4'h0;
      4'h4:    y = 4'h5;
      4'h5:    y = 4'h4;
      4'h6:    y = 4'hB;
      4'h7:    y = 4'hC;
      4'h8:    y = 4'hD;
      4'h9:    y = 4'hA;
      4'hA:    y = 4'h9;
      4'hB:    y = 4'h6;
      4'hC:    y = 4'h7;
      4'hD:    y = 4'h8;
      4'hE:    y = 4'h2;
      default: y = 4'h1;
    endcase
    return y;
  endfunction

  state_t            state_p0, state_d;
  logic [CW-1:0]     cnt_p0, cnt_d;
  logic [DATA_W-1:0] data_p0, data_d;
  logic [GW-1:0]     grp_in, grp_out;

  // Current nibble group through NPC parallel P boxes
  always_comb begin
    grp_in  = data_p0[int'(cnt_p0)*GW +: GW];
    grp_out = '0;
    for (int i = 0; i < NPC; i++) begin
      grp_out[i*4 +: 4] = p_box(grp_in[i*4 +: 4]);
    end
  end

  always_comb begin
    state_d   = state_p0;
    cnt_d     = cnt_p0;
    data_d    = data_p0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_p0)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        data_d[int'(cnt_p0)*GW +: GW] = grp_out;
        if (cnt_p0 == CW'(G - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_p0 + 1'b1;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; the data register is cleared too so out_data reads zero after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= S_IDLE;
      cnt_p0   <= '0;
      data_p0  <= '0;
    end else begin
      state_p0 <= state_d;
      cnt_p0   <= cnt_d;
      data_p0  <= data_d;
    end
  end

  assign out_data = data_p0;

endmodule

// File: tb/tb_anubis_p_nibble_serializer.sv
// Directed bench for anubis_p_nibble_serializer at NPC=1 (G=32) and NPC=4 (G=8).
module tb_anubis_p_nibble_serializer;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic          busy      [2];
  logic [DW-1:0] in_data   [2];
  logic [DW-1:0] out_data  [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  anubis_p_nibble_serializer #(.DATA_W(DW), .NPC(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0])
  );

  anubis_p_nibble_serializer #(.DATA_W(DW), .NPC(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1])
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ov(input int s, output int n);
    n = 0;
    while (out_valid[s] !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_word(input int s, input logic [DW-1:0] din, input logic [DW-1:0] exp,
                          input string tag);
    int n;
    int lat;
    lat = (s == 0) ? 32 : 8;
    chk({tag, " idle_ready"}, in_ready[s], 1);
    in_data[s]   = din;
    in_valid[s]  = 1'b1;
    out_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[s] = 1'b0;
    chk({tag, " busy"}, busy[s], 1);
    wait_ov(s, n);
    chk({tag, " latency"}, n, lat);
    chk({tag, " data"}, out_data[s], exp);
    @(posedge clk);
    #1;
    chk({tag, " ov_drop"}, out_valid[s], 0);
    chk({tag, " in_ready"}, in_ready[s], 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0] = '{128'h0, {32{4'h3}}};
    vecs[1] = '{128'h0123456789ABCDEF_0123456789ABCDEF, 128'h3FE054BCDA967821_3FE054BCDA967821};
    vecs[2] = '{128'h3FE054BCDA967821_3FE054BCDA967821, 128'h0123456789ABCDEF_0123456789ABCDEF};
    vecs[3] = '{{32{4'h5}}, {32{4'h4}}};
    vecs[4] = '{{32{4'hF}}, {32{4'h1}}};
    vecs[5] = '{128'h0000_0000_0000_0000_0000_0000_0000_000F, 128'h3333_3333_3333_3333_3333_3333_3333_3331};
    vecs[6] = '{128'hF000_0000_0000_0000_0000_0000_0000_0000, 128'h1333_3333_3333_3333_3333_3333_3333_3333};

    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      in_data[s]   = '0;
      out_ready[s] = 1'b1;
    end
    #2 rst = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset%0d in_ready", s), in_ready[s], 1);
      chk($sformatf("reset%0d out_valid", s), out_valid[s], 0);
      chk($sformatf("reset%0d busy", s), busy[s], 0);
      chk($sformatf("reset%0d out_data", s), out_data[s], 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      for (int s = 0; s < 2; s++) begin
        run_word(s, vecs[i].din, vecs[i].exp, $sformatf("v%0d_npc%0d", i, (s == 0) ? 1 : 4));
      end
    end

    // Backpressure with a held in_valid that must wait for the output handshake
    out_ready[0] = 1'b0;
    in_data[0]   = 128'h0123456789ABCDEF_0123456789ABCDEF;
    in_valid[0]  = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    wait_ov(0, n);
    chk("bp latency", n, 32);
    in_data[0]  = {32{4'h5}};
    in_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d out_valid", k), out_valid[0], 1);
      chk($sformatf("bp%0d out_data", k), out_data[0], 128'h3FE054BCDA967821_3FE054BCDA967821);
      chk($sformatf("bp%0d in_ready", k), in_ready[0], 0);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp handshake out_valid", out_valid[0], 0);
    chk("bp handshake in_ready", in_ready[0], 1);
    chk("bp handshake busy", busy[0], 0);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    chk("bp next accept busy", busy[0], 1);
    wait_ov(0, n);
    chk("bp next latency", n, 32);
    chk("bp next data", out_data[0], {32{4'h4}});
    @(posedge clk);
    #1;
    chk("bp next ov_drop", out_valid[0], 0);

    // in_valid pulses during RUN and DONE are ignored
    out_ready[0] = 1'b0;
    in_data[0]   = {32{4'hF}};
    in_valid[0]  = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_data[0]  = 128'h0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    wait_ov(0, n);
    chk("pulse run latency", n + 4, 32);
    chk("pulse run data", out_data[0], {32{4'h1}});
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    chk("pulse done out_valid", out_valid[0], 1);
    chk("pulse done data", out_data[0], {32{4'h1}});
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("pulse done ov_drop", out_valid[0], 0);
    chk("pulse done not accepted", busy[0], 0);

    // Reset in the middle of RUN discards the partial word
    in_data[0]  = 128'h0123456789ABCDEF_0123456789ABCDEF;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", out_valid[0], 0);
    chk("midrst in_ready", in_ready[0], 1);
    chk("midrst busy", busy[0], 0);
    chk("midrst out_data", out_data[0], 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    run_word(0, {32{4'hF}}, {32{4'h1}}, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
